// File: rtl/fb_scanout_pkg.sv
// rtl/fb_scanout_pkg.sv - shared constants and types for the frame-buffer scanout path
package fb_scanout_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int FB_ADDR_W = 19;
  localparam int COLOR_W   = 6;
  localparam int CH_W      = 2;
  localparam int R_LSB     = 4;
  localparam int G_LSB     = 2;
  localparam int B_LSB     = 0;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } raster_sig_t;

  // Blanked, syncs idle: what the pins show before any pixel has come through.
  localparam raster_sig_t RASTER_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/fb_scanout_controller_timing.sv
// rtl/fb_scanout_controller_timing.sv - pixel-tick divider and raster counters with raw sync/active decode
module vga_timing_counter
  import fb_scanout_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        tick,
  output raster_sig_t raw,
  output logic        frame_start,
  output logic        wrap
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  assign tick = enable && (div == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      div <= '0;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  assign raw = '{active: (h_cnt < H_ACT) && (v_cnt < V_ACT),
                 hsync:  !((h_cnt >= HS_BEG) && (h_cnt < HS_END)),
                 vsync:  !((v_cnt >= VS_BEG) && (v_cnt < VS_END))};

  assign frame_start = tick && (h_cnt == '0) && (v_cnt == '0);
  assign wrap        = tick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

endmodule

// File: rtl/fb_scanout_controller.sv
// rtl/fb_scanout_controller.sv - raster-order frame-buffer reader driving aligned VGA pins
module fb_scanout_controller
  import fb_scanout_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = 2,
  parameter int RD_LAT   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  output logic                 fb_rd_en,
  output logic [FB_ADDR_W-1:0] fb_rd_addr,
  input  logic [COLOR_W-1:0]   fb_rd_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 blank_n,
  output logic [CH_W-1:0]      vga_r,
  output logic [CH_W-1:0]      vga_g,
  output logic [CH_W-1:0]      vga_b,
  output logic                 frame_start
);

  logic        tick;
  logic        tc_frame_start;
  logic        wrap;
  raster_sig_t raw;
  raster_sig_t dly [RD_LAT];

  vga_timing_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst),
    .enable      (enable),
    .tick        (tick),
    .raw         (raw),
    .frame_start (tc_frame_start),
    .wrap        (wrap)
  );

  // With CLK_DIV=1 the tick is live while reset is held, so the strobes are gated by reset too.
  assign fb_rd_en    = rst && tick && raw.active;
  assign frame_start = rst && tc_frame_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fb_rd_addr <= '0;
    end else if (!enable) begin
      fb_rd_addr <= '0;
    end else if (tick) begin
      if (wrap)            fb_rd_addr <= '0;
      else if (raw.active) fb_rd_addr <= fb_rd_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) dly[i] <= RASTER_IDLE;
    end else if (!enable) begin
      for (int i = 0; i < RD_LAT; i++) dly[i] <= RASTER_IDLE;
    end else if (tick) begin
      dly[0] <= raw;
      for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  // Pins load on the tick the read data returns, so sync, blank and colour change together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
      vga_r   <= '0;
      vga_g   <= '0;
      vga_b   <= '0;
    end else if (!enable) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
      vga_r   <= '0;
      vga_g   <= '0;
      vga_b   <= '0;
    end else if (tick) begin
      hsync   <= dly[RD_LAT-1].hsync;
      vsync   <= dly[RD_LAT-1].vsync;
      blank_n <= dly[RD_LAT-1].active;
      if (dly[RD_LAT-1].active) begin
        vga_r <= fb_rd_data[R_LSB +: CH_W];
        vga_g <= fb_rd_data[G_LSB +: CH_W];
        vga_b <= fb_rd_data[B_LSB +: CH_W];
      end else begin
        vga_r <= '0;
        vga_g <= '0;
        vga_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fb_scanout_controller.sv
// tb/tb_fb_scanout_controller.sv - model-checked bench for fb_scanout_controller on a reduced raster
module tb_fb_scanout_controller;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;

  typedef struct {
    bit rd_en;
    int addr;
    bit fs;
    bit hs;
    bit vs;
    bit bn;
    int rgb;
    int drive;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [5:0]  data_a = 6'h3F, data_b = 6'h3F;

  logic        a_rd_en, a_hs, a_vs, a_bn, a_fs;
  logic [18:0] a_addr;
  logic [1:0]  a_r, a_g, a_b;
  logic        b_rd_en, b_hs, b_vs, b_bn, b_fs;
  logic [18:0] b_addr;
  logic [1:0]  b_r, b_g, b_b;

  fb_scanout_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(2), .RD_LAT(1)
  ) dut_a (
    .clk(clk), .rst(rst_n), .enable(enable),
    .fb_rd_en(a_rd_en), .fb_rd_addr(a_addr), .fb_rd_data(data_a),
    .hsync(a_hs), .vsync(a_vs), .blank_n(a_bn),
    .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .frame_start(a_fs)
  );

  fb_scanout_controller #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .CLK_DIV(1), .RD_LAT(3)
  ) dut_b (
    .clk(clk), .rst(rst_n), .enable(enable),
    .fb_rd_en(b_rd_en), .fb_rd_addr(b_addr), .fb_rd_data(data_b),
    .hsync(b_hs), .vsync(b_vs), .blank_n(b_bn),
    .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .frame_start(b_fs)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  int j = 0, cyc = 0;

  function automatic bit act_at(int i);
    int p = i % FT;
    return ((p % HT) < HA) && ((p / HT) < VA);
  endfunction

  function automatic int addr_at(int i);
    int p = i % FT;
    return (p / HT) * HA + (p % HT);
  endfunction

  function automatic int mem(int a);
    return a & 63;
  endfunction

  // Everything follows from j, the number of enabled clock edges since the last restart.
  function automatic exp_t model(int jj, int d, int l, bit live);
    exp_t e;
    bit tick = ((jj % d) == d - 1);
    int n = jj / d;
    int k = jj / d;
    int i = k - 1 - l;
    e.rd_en = live && tick && act_at(n);
    e.addr  = addr_at(n);
    e.fs    = live && tick && ((n % FT) == 0);
    e.drive = 63;
    if (tick && (n - l) >= 0 && act_at(n - l)) e.drive = mem(addr_at(n - l));
    if (i < 0) begin
      e.hs = 1; e.vs = 1; e.bn = 0; e.rgb = 0;
    end else begin
      int p = i % FT;
      int h = p % HT;
      int v = p / HT;
      e.hs  = !(h >= HA + HFP && h < HA + HFP + HS);
      e.vs  = !(v >= VA + VFP && v < VA + VFP + VS);
      e.bn  = act_at(i);
      e.rgb = e.bn ? mem(addr_at(i)) : 0;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  bit lit_on = 0, restart_pending = 0, done_hs = 0, done_vs = 0, done_bn = 0, seen_bn_hi = 0, done_b = 0;
  int a_rdn = 0, a_frames = 0, a_last_rd = 0, c54 = -1, hs_run = 0, vs_run = 0, bn_run = 0, start_cyc = -1;

  task automatic step(input bit en, input bit rn);
    exp_t ea, eb;
    bit live;
    enable = en;
    if (!rn) begin rst_n = 1'b0; j = 0; end else rst_n = 1'b1;
    if (!en || !rn) restart_pending = 1;
    live = rst_n && enable;
    if (live && start_cyc < 0) start_cyc = cyc;
    ea = model(j, 2, 1, live);
    eb = model(j, 1, 3, live);
    data_a = 6'(ea.drive);
    data_b = 6'(eb.drive);
    #1;
    chk("a_rd_en", int'(a_rd_en), int'(ea.rd_en));
    chk("a_frame_start", int'(a_fs), int'(ea.fs));
    if (ea.rd_en) chk("a_addr", int'(a_addr), ea.addr);
    chk("a_hsync", int'(a_hs), int'(ea.hs));
    chk("a_vsync", int'(a_vs), int'(ea.vs));
    chk("a_blank_n", int'(a_bn), int'(ea.bn));
    chk("a_rgb", int'({a_r, a_g, a_b}), ea.rgb);
    chk("b_rd_en", int'(b_rd_en), int'(eb.rd_en));
    chk("b_frame_start", int'(b_fs), int'(eb.fs));
    if (eb.rd_en) chk("b_addr", int'(b_addr), eb.addr);
    chk("b_hsync", int'(b_hs), int'(eb.hs));
    chk("b_vsync", int'(b_vs), int'(eb.vs));
    chk("b_blank_n", int'(b_bn), int'(eb.bn));
    chk("b_rgb", int'({b_r, b_g, b_b}), eb.rgb);

    if (lit_on) begin
      if (a_rd_en) begin
        if (a_fs) begin
          if (a_frames == 1) begin
            chk("a_frame_rd_count", a_rdn, 96);
            chk("a_wrap_addr", int'(a_addr), 0);
          end
          a_frames++;
          a_rdn = 0;
        end
        if (a_frames == 1) begin
          if (a_rdn == 0) chk("a_first_addr", int'(a_addr), 0);
          if (a_rdn == 16) begin
            chk("a_line1_addr", int'(a_addr), 16);
            chk("a_line_gap_clks", cyc - a_last_rd, 18);
          end
          if (a_rdn == 95) chk("a_last_addr", int'(a_addr), 95);
          if (a_addr == 19'd54) c54 = cyc;
        end
        a_rdn++;
        a_last_rd = cyc;
      end
      if (c54 >= 0 && cyc == c54 + 3) begin
        chk("a_colour_r", int'(a_r), 3);
        chk("a_colour_g", int'(a_g), 1);
        chk("a_colour_b", int'(a_b), 2);
      end
      if (!a_hs) hs_run++;
      else begin
        if (hs_run > 0 && !done_hs) begin chk("a_hsync_width_clks", hs_run, 6); done_hs = 1; end
        hs_run = 0;
      end
      if (!a_vs) vs_run++;
      else begin
        if (vs_run > 0 && !done_vs) begin chk("a_vsync_width_clks", vs_run, 96); done_vs = 1; end
        vs_run = 0;
      end
      if (a_bn) begin
        if (bn_run > 0 && !done_bn) begin chk("a_hblank_width_clks", bn_run, 16); done_bn = 1; end
        seen_bn_hi = 1;
        bn_run = 0;
      end else if (seen_bn_hi) bn_run++;
      if (!done_b && b_bn) begin chk("b_first_blank_n_delay", cyc - start_cyc, 4); done_b = 1; end
    end else if (restart_pending && live && a_rd_en) begin
      chk("a_restart_addr", int'(a_addr), 0);
      chk("a_restart_frame_start", int'(a_fs), 1);
      restart_pending = 0;
    end

    @(posedge clk);
    if (rst_n && enable) j++; else j = 0;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1);
    restart_pending = 0;
    lit_on = 1;
    for (int i = 0; i < 1100; i++) step(1'b1, 1'b1);
    lit_on = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 400; i++) step(1'b1, 1'b1);
    if (restart_pending) chk("a_restart_seen", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
